ble_uart_rx: RTL
================

# ble_uart_rx

Receive-side UART deserializer for the RN4871 Bluetooth PMOD. It samples the module's TX line (pmod pin 3) with 16x oversampling and validates start and stop bits. Good bytes go into a small first-word-fall-through FIFO that the SoC consumes through a valid/ready handshake. It replaces the raw pass-through when the CPU, rather than the host UART, owns the BLE link.

## Interface
Parameters:
- CLKS_PER_TICK, 27, clocks per oversample tick. 16 ticks make one bit. The default gives 115200 baud at 50 MHz. Legal range 2..1023.
- FIFO_DEPTH, 8, byte entries. Must be a power of two, 2..64.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- i_rxd  input  1  asynchronous serial line from the RN4871 TX pin. Idle high.
- o_data  output  8  byte at the FIFO head. Valid only while o_valid is high.
- o_valid  output  1  FIFO not empty.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_frame_err  output  1  one-cycle pulse when a stop bit samples low.
- o_overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Synchronizer**
  - i_rxd passes through two flops, both reset to 1. All logic uses the second-stage value, rxs.
- **Tick generator**
  - Counter runs 0..CLKS_PER_TICK-1. tick = (counter == CLKS_PER_TICK-1).
  - The counter is forced to 0 in IDLE, so the first tick after start detection lands CLKS_PER_TICK clocks later.
- **Frame FSM** (5 states, reset to IDLE). tcnt is a 4-bit tick counter and bidx a 3-bit bit index.
  - IDLE: on rxs==0, go to START with tcnt=0.
  - START: on each tick, tcnt++. At the tick where tcnt==7 (mid start bit):
    - if rxs==0, go to DATA with tcnt=0, bidx=0;
    - otherwise it is a glitch: return to IDLE with no output.
  - DATA: on each tick, tcnt++. At the tick where tcnt==15:
    - shift rxs into shreg LSB-first (shreg <= {rxs, shreg[7:1]});
    - if bidx==7, go to STOP with tcnt=0; otherwise bidx++.
  - STOP: at the tick where tcnt==15:
    - if rxs==1, push shreg, then go to IDLE;
    - if rxs==0, pulse o_frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. This stops a held-low line (break condition) from being read as repeated 0x00 frames.
- **FIFO**
  - Circular buffer with read/write pointers one bit wider than the address.
  - o_data = mem[rd_ptr], registered storage, first-word fall-through.
  - Pop when o_valid && i_ready. Push on a good stop bit.
  - Push while full with no pop in the same cycle: byte dropped, o_overrun pulses, contents unchanged.
  - Push and pop in the same cycle, including when full: both happen, o_count unchanged, no overrun.
  - Pop while empty is ignored.
- **Reset values**
  - o_valid=0, o_count=0, o_frame_err=0, o_overrun=0, FSM=IDLE, pointers=0.
  - o_data is don't-care while o_valid=0.
  - Reset mid-frame discards the partial byte and all FIFO contents. After reset the synchronizer holds 1, so a line already low at reset release is detected as a start 2 clocks later.

## Timing
- Nominal bit period = 16*CLKS_PER_TICK clocks.
- Sample points:
  - start bit validated 8*CLKS_PER_TICK clocks after rxs falls;
  - data bit n sampled (8+16*(n+1))*CLKS_PER_TICK clocks after rxs falls;
  - stop bit sampled at 152*CLKS_PER_TICK.
- Push occurs in the cycle of the stop-bit sample tick.
- o_valid and o_count update on the next rising edge after the push. With the 2-flop synchronizer, that is 152*CLKS_PER_TICK+3 clocks from the i_rxd falling edge.
- o_frame_err and o_overrun are registered and high for exactly one clock.
- Supports back-to-back frames with a 1-bit stop. The FSM is in IDLE again by mid stop bit, with half a bit of margin.
- Tolerates about ±4% baud mismatch.
- Handshake: the consumer may hold i_ready high continuously for one byte per clock. o_data changes only on a pop or on a push into an empty FIFO.

## Test plan
Use CLKS_PER_TICK=4 (bit = 64 clocks) and FIFO_DEPTH=4 unless stated otherwise.
- Single frame 0xA5 with i_ready=1: o_valid pulses for one clock carrying o_data=0xA5 at 611 clocks after the start edge. No error pulses.
- Low glitch on i_rxd lasting 20 clocks while idle: no o_valid, no o_frame_err, and the FSM is back in IDLE before a following valid 0x3C frame, which is received correctly.
- Frame 0x55 with the stop bit driven low: one o_frame_err pulse and o_count stays 0. Then hold the line low for 500 clocks and release it, followed by frame 0x81: only 0x81 is received, with no spurious 0x00 bytes.
- Five back-to-back frames 0x01..0x05 with i_ready=0: o_count reaches 4, o_overrun pulses once on the fifth byte, and draining yields 0x01,0x02,0x03,0x04.
- With the FIFO full, i_ready=1 timed to coincide with the next push: o_count stays 4, no o_overrun, and the new byte appears last in drain order.
- Assert rst during DATA bit 3 of frame 0xF0 with 2 bytes queued: after reset o_valid=0 and o_count=0, and a subsequent frame 0x99 is received correctly.

Source files
------------

// File: rtl/ble_uart_rx.sv
// ble_uart_rx: 16x-oversampled UART receiver for the RN4871 BLE PMOD TX line.
// Validates start/stop bits, suppresses break conditions, and queues good
// bytes in a first-word-fall-through FIFO drained by a valid/ready handshake.
module ble_uart_rx #(
  parameter int unsigned CLKS_PER_TICK = 27,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rxd,
  output logic [7:0]                   o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(FIFO_DEPTH):0]  o_count,
  output logic                         o_frame_err,
  output logic                         o_overrun
);

  localparam int unsigned TW = $clog2(CLKS_PER_TICK);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          rx_meta;
  logic          rxs;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    tcnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;

  logic          mid_tick_c;
  logic          end_tick_c;
  logic          start_ok_c;
  logic          sample_c;
  logic          push_c;
  logic          ferr_c;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_c;
  logic          full_c;
  logic          pop_c;
  logic          wr_en_c;
  logic          ovr_c;

  // Two-flop synchronizer on the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_rxd;
      rxs     <= rx_meta;
    end
  end

  // Oversample tick divider, held at zero whenever no frame is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE || state == S_BREAK) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick       = (tick_cnt == TW'(CLKS_PER_TICK - 1));
  assign mid_tick_c = tick && (tcnt == 4'd7);
  assign end_tick_c = tick && (tcnt == 4'd15);

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!rxs) state_nxt = S_START;
      end
      S_START: begin
        if (mid_tick_c) state_nxt = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (end_tick_c && bidx == 3'd7) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (end_tick_c) state_nxt = rxs ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame FSM outputs: strobes for the datapath, FIFO and error flags.
  always_comb begin
    start_ok_c = 1'b0;
    sample_c   = 1'b0;
    push_c     = 1'b0;
    ferr_c     = 1'b0;
    case (state)
      S_START: start_ok_c = mid_tick_c && !rxs;
      S_DATA:  sample_c   = end_tick_c;
      S_STOP: begin
        push_c = end_tick_c && rxs;
        ferr_c = end_tick_c && !rxs;
      end
      default: ;
    endcase
  end

  // Tick counter, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= '0;
      bidx  <= '0;
      shreg <= '0;
    end else begin
      if (state == S_IDLE) begin
        tcnt <= '0;
      end else if (tick) begin
        tcnt <= start_ok_c ? 4'd0 : tcnt + 4'd1;
      end
      if (start_ok_c) begin
        bidx <= '0;
      end else if (sample_c) begin
        bidx <= bidx + 3'd1;
      end
      if (sample_c) begin
        shreg <= {rxs, shreg[7:1]};
      end
    end
  end

  assign count_c = wr_ptr - rd_ptr;
  assign full_c  = (count_c == CW'(FIFO_DEPTH));
  assign pop_c   = o_valid && i_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_en_c = push_c && (!full_c || pop_c);
  assign ovr_c   = push_c && full_c && !pop_c;

  // FIFO storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr[AW-1:0]] <= shreg;
    end
  end

  // FIFO pointers, one bit wider than the address to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + CW'(1);
      if (pop_c)   rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // One-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= ferr_c;
      o_overrun   <= ovr_c;
    end
  end

  assign o_count = count_c;
  assign o_valid = (count_c != '0);
  assign o_data  = mem[rd_ptr[AW-1:0]];

endmodule
